// File: rtl/bf_pkg.sv
// Shared BF definitions: opcode encoding, ASCII command characters, loader error codes and FSM states.
package bf_pkg;

  typedef enum logic [2:0] {
    OP_IN    = 3'b000,
    OP_OUT   = 3'b001,
    OP_END   = 3'b010,
    OP_LOOP  = 3'b011,
    OP_LEFT  = 3'b100,
    OP_RIGHT = 3'b101,
    OP_DEC   = 3'b110,
    OP_INC   = 3'b111
  } bf_op_t;

  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_GT    = 8'h3E;
  localparam logic [7:0] CH_LT    = 8'h3C;
  localparam logic [7:0] CH_LBR   = 8'h5B;
  localparam logic [7:0] CH_RBR   = 8'h5D;
  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_NUL   = 8'h00;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'b00,
    ERR_STRAY_CLOSE = 2'b01,
    ERR_UNCLOSED    = 2'b10,
    ERR_OVERFLOW    = 2'b11
  } load_err_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_DONE  = 2'b10,
    ST_ERROR = 2'b11
  } load_state_t;

endpackage

// File: rtl/bf_char_encoder.sv
// Combinational ASCII -> BF opcode encoder; o_is_cmd is low for any non-command byte.
module bf_char_encoder
  import bf_pkg::*;
(
  input  logic [7:0] i_char,
  output logic       o_is_cmd,
  output bf_op_t     o_op
);

  always_comb begin
    o_is_cmd = 1'b1;
    o_op     = OP_IN;
    case (i_char)
      CH_PLUS:  o_op = OP_INC;
      CH_MINUS: o_op = OP_DEC;
      CH_GT:    o_op = OP_RIGHT;
      CH_LT:    o_op = OP_LEFT;
      CH_LBR:   o_op = OP_LOOP;
      CH_RBR:   o_op = OP_END;
      CH_DOT:   o_op = OP_OUT;
      CH_COMMA: o_op = OP_IN;
      default:  o_is_cmd = 1'b0;
    endcase
  end

endmodule

// File: rtl/bf_program_loader.sv
// BF program loader: encodes an ASCII byte stream into opcodes and writes them to program RAM.
// Optional bracket checking is enabled by defining BF_LOADER_BRACKET_CHECK_EN.
module bf_program_loader
  import bf_pkg::*;
#(
  parameter int         ADDR_W    = 10,
  parameter int         DEPTH     = 1024,
  parameter int         MAX_NEST  = 16,
  parameter logic [7:0] TERM_CHAR = 8'h21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        wr_code,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   prog_len,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  load_state_t       r_state;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [2:0]        r_wr_code;
  logic              r_done;
  logic              r_err;
  load_err_t         r_err_code;
  logic [ADDR_W:0]   r_prog_len;

  logic   w_is_cmd;
  bf_op_t w_op;
  logic   w_xfer;
  logic   w_is_term;
  logic   w_len_full;
  logic   w_nest_full;
  logic   w_stray;
  logic   w_open;
  logic   w_write;
  logic   w_start_load;

  bf_char_encoder u_enc (
    .i_char   (in_data),
    .o_is_cmd (w_is_cmd),
    .o_op     (w_op)
  );

  assign in_ready     = (r_state == ST_LOAD);
  assign busy         = (r_state == ST_LOAD);
  assign w_xfer       = in_valid && (r_state == ST_LOAD);
  assign w_is_term    = (in_data == TERM_CHAR) || (in_data == CH_NUL);
  assign w_len_full   = (r_prog_len == DEPTH_L);
  assign w_write      = w_xfer && w_is_cmd && !w_len_full && !w_nest_full && !w_stray;
  assign w_start_load = start && (r_state != ST_LOAD);

`ifdef BF_LOADER_BRACKET_CHECK_EN
  localparam int                  DEPTH_CW = $clog2(MAX_NEST + 1);
  localparam logic [DEPTH_CW-1:0] NEST_MAX = DEPTH_CW'(MAX_NEST);

  logic [DEPTH_CW-1:0] r_depth;

  assign w_nest_full = (w_op == OP_LOOP) && (r_depth == NEST_MAX);
  assign w_stray     = (w_op == OP_END) && (r_depth == '0);
  assign w_open      = (r_depth != '0);

  always_ff @(posedge clk) begin
    if (rst || w_start_load) begin
      r_depth <= '0;
    end else if (w_write && (w_op == OP_LOOP)) begin
      r_depth <= r_depth + DEPTH_CW'(1);
    end else if (w_write && (w_op == OP_END)) begin
      r_depth <= r_depth - DEPTH_CW'(1);
    end
  end
`else
  // Without bracket tracking the stream can never be left with an open loop.
  assign w_nest_full = 1'b0;
  assign w_stray     = 1'b0;
  assign w_open      = (MAX_NEST < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_code  <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_prog_len <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (w_xfer) begin
            if (w_is_term) begin
              if (w_open) begin
                r_state    <= ST_ERROR;
                r_err      <= 1'b1;
                r_err_code <= ERR_UNCLOSED;
              end else begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end
            end else if (w_is_cmd) begin
              // Overflow (program or nesting) wins over a stray ']' on the same byte.
              if (w_len_full || w_nest_full) begin
                r_state    <= ST_ERROR;
                r_err      <= 1'b1;
                r_err_code <= ERR_OVERFLOW;
              end else if (w_stray) begin
                r_state    <= ST_ERROR;
                r_err      <= 1'b1;
                r_err_code <= ERR_STRAY_CLOSE;
              end else begin
                r_wr_en    <= 1'b1;
                r_wr_addr  <= r_prog_len[ADDR_W-1:0];
                r_wr_code  <= w_op;
                r_prog_len <= r_prog_len + (ADDR_W + 1)'(1);
              end
            end
          end
        end
        default: begin
          if (start) begin
            r_state    <= ST_LOAD;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_prog_len <= '0;
          end
        end
      endcase
    end
  end

  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_code  = r_wr_code;
  assign done     = r_done;
  assign err      = r_err;
  assign err_code = r_err_code;
  assign prog_len = r_prog_len;

endmodule

// File: tb/tb_bf_program_loader.sv
// Testbench for bf_program_loader: directed vector table, hand sequences and randomized streams vs a reference model.
module tb_bf_program_loader;
  import bf_pkg::*;

  localparam int ADDR_W   = 5;
  localparam int DEPTH    = 20;
  localparam int MAX_NEST = 4;
`ifdef BF_LOADER_BRACKET_CHECK_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_code;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   prog_len;
  logic              err;
  logic [1:0]        err_code;

  bf_program_loader #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_NEST(MAX_NEST), .TERM_CHAR(8'h21)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_code(wr_code),
    .busy(busy), .done(done), .prog_len(prog_len), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int code;
  } wr_t;

  wr_t wq[$];  // writes observed on the RAM port
  wr_t ew[$];  // writes expected

  int n_cmp = 0;
  int n_mis = 0;

  always @(negedge clk) begin
    if (wr_en === 1'b1) wq.push_back('{int'(wr_addr), int'(wr_code)});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: walks the byte stream by the loader's rules and stops at the deciding byte.
  task automatic model(input byte unsigned b[$], output int len, output bit d, output bit e,
                       output int code);
    string cmds = "+-><[].,";
    int depth = 0;
    ew.delete();
    len = 0; d = 0; e = 0; code = 0;
    foreach (b[i]) begin
      int p = -1;
      byte unsigned c = b[i];
      if (c == 8'h21 || c == 8'h00) begin
        if (BR && depth != 0) begin e = 1; code = 2; end
        else d = 1;
        return;
      end
      for (int k = 0; k < 8; k++) if (cmds[k] == c) p = k;
      if (p < 0) continue;
      if (len == DEPTH) begin e = 1; code = 3; return; end
      if (BR && p == 4 && depth == MAX_NEST) begin e = 1; code = 3; return; end
      if (BR && p == 5 && depth == 0) begin e = 1; code = 1; return; end
      ew.push_back('{len, 7 - p});
      len++;
      if (p == 4) depth++;
      if (p == 5) depth--;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers each byte after gmin..gmax idle cycles; stops once the loader no longer accepts.
  task automatic drive(input byte unsigned b[$], input int gmin, input int gmax);
    foreach (b[i]) begin
      repeat ($urandom_range(gmax, gmin)) @(negedge clk);
      if (in_ready !== 1'b1) break;
      in_valid = 1'b1;
      in_data  = b[i];
      @(negedge clk);
      in_valid = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_result(input string tag, input int len, input bit d, input bit e,
                              input int code);
    chk({tag, " done"}, done, d);
    chk({tag, " err"}, err, e);
    chk({tag, " err_code"}, err_code, code);
    chk({tag, " prog_len"}, prog_len, len);
    chk({tag, " in_ready"}, in_ready, (d || e) ? 0 : 1);
    chk({tag, " nwrites"}, wq.size(), ew.size());
    for (int i = 0; i < ew.size() && i < wq.size(); i++) begin
      chk($sformatf("%s wr_addr[%0d]", tag, i), wq[i].addr, ew[i].addr);
      chk($sformatf("%s wr_code[%0d]", tag, i), wq[i].code, ew[i].code);
    end
  endtask

  function automatic void str_to_q(input string s, output byte unsigned q[$]);
    q.delete();
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endfunction

  typedef struct {
    string       prog;
    bit          nul_term;
    int          n_wr;
    logic [29:0] ops;   // opcode i in bits [3i+2:3i]
    bit          d;
    bit          e;
    int          code;
  } vec_t;

  vec_t tv[8];

  initial begin
    byte unsigned q[$];
    string s;
    int len, code;
    bit d, e;

    tv[0] = '{"+[-].!", 0, 5, 30'o12637, 1, 0, 0};
    tv[1] = '{"a+ \n>x", 1, 2, 30'o57, 1, 0, 0};
    tv[2] = '{"]!", 0, BR ? 0 : 1, 30'o2, !BR, BR, BR ? 1 : 0};
    tv[3] = '{"[[+]!", 0, 4, 30'o2733, !BR, BR, BR ? 2 : 0};
    s = ""; repeat (21) s = {s, "+"};
    tv[4] = '{{s, "!"}, 0, 20, 30'o7777777777, 0, 1, 3};
    tv[5] = '{"[[[[[!", 0, BR ? 4 : 5, 30'o33333, !BR, BR, BR ? 3 : 0};
    s = ""; repeat (20) s = {s, "+"};
    tv[6] = '{{s, "]!"}, 0, 20, 30'o7777777777, 0, 1, 3};
    tv[7] = '{"+!+", 0, 1, 30'o7, 1, 0, 0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", in_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset wr_en", wr_en, 0);
    chk("reset wr_addr", wr_addr, 0);
    chk("reset wr_code", wr_code, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset err_code", err_code, 0);
    chk("reset prog_len", prog_len, 0);

    foreach (tv[t]) begin
      str_to_q(tv[t].prog, q);
      if (tv[t].nul_term) q.push_back(8'h00);
      ew.delete();
      for (int i = 0; i < tv[t].n_wr; i++)
        ew.push_back('{i, (i < 10) ? int'(tv[t].ops[3*i +: 3]) : 7});
      pulse_start();
      chk($sformatf("vec%0d busy", t), busy, 1);
      wq.delete();
      drive(q, 0, 0);
      check_result($sformatf("vec%0d", t), tv[t].n_wr, tv[t].d, tv[t].e, tv[t].code);
    end

    // start during LOAD must not clear the running count
    pulse_start();
    wq.delete();
    str_to_q("++", q);
    drive(q, 0, 0);
    pulse_start();
    str_to_q("+!", q);
    drive(q, 0, 0);
    ew.delete();
    for (int i = 0; i < 3; i++) ew.push_back('{i, 7});
    check_result("start_in_load", 3, 1, 0, 0);

    // alternating in_valid gaps, then reset in the middle of the load
    pulse_start();
    wq.delete();
    str_to_q("+-><", q);
    drive(q, 1, 1);
    ew.delete();
    ew.push_back('{0, 7}); ew.push_back('{1, 6}); ew.push_back('{2, 5}); ew.push_back('{3, 4});
    check_result("gapped", 4, 0, 0, 0);
    chk("gapped busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst in_ready", in_ready, 0);
    chk("midrst busy", busy, 0);
    chk("midrst wr_addr", wr_addr, 0);
    chk("midrst wr_code", wr_code, 0);
    chk("midrst prog_len", prog_len, 0);
    chk("midrst done", done, 0);
    chk("midrst err", err, 0);
    pulse_start();
    wq.delete();
    str_to_q(".,!", q);
    drive(q, 0, 0);
    ew.delete();
    ew.push_back('{0, 1}); ew.push_back('{1, 0});
    check_result("after_rst", 2, 1, 0, 0);

    // randomized streams against the reference model
    for (int r = 0; r < 40; r++) begin
      string alpha = "+-><[[]].,a \n";
      int n = $urandom_range(26, 1);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(alpha[$urandom_range(alpha.len() - 1, 0)]);
      q.push_back(($urandom_range(1, 0) == 0) ? 8'h00 : 8'h21);
      model(q, len, d, e, code);
      pulse_start();
      wq.delete();
      drive(q, 0, 2);
      check_result($sformatf("rand%0d", r), len, d, e, code);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
